// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges ALU and load-unit writeback requests onto the single register file
//   write port. Round-robin arbitration is used when both request together.
//   Also keeps a 32-entry busy scoreboard that decode uses to detect pending
//   destination writes and raise a stall.
//
// Ports
//   clk, rst                          clock, async active-high reset
//   alu_valid/alu_rd/alu_data         ALU writeback request
//   alu_ready                         ALU request granted this cycle (comb)
//   mem_valid/mem_rd/mem_data         load-unit writeback request
//   mem_ready                         load-unit request granted this cycle (comb)
//   reserve_en/reserve_address        mark a destination register pending
//   query_a_address/query_b_address   decode source operands
//   query_a_busy/query_b_busy         queried register has a pending write
//   stall                             either queried register is busy
//   register_write_en/rd_address/
//   register_write_data               registered register file write port
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        reserve_en,
  input  logic [4:0]  reserve_address,
  input  logic [4:0]  query_a_address,
  input  logic [4:0]  query_b_address,
  output logic        query_a_busy,
  output logic        query_b_busy,
  output logic        stall,
  output logic        register_write_en,
  output logic [4:0]  rd_address,
  output logic [31:0] register_write_data
);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_t;

  prio_t       prio;
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        grant_alu;
  logic        grant_mem;

  // Grants are forced low while reset is held so no request is consumed
  // that the output stage would then discard.
  always_comb begin
    grant_alu = !rst && alu_valid && (!mem_valid || (prio == PRIO_ALU));
    grant_mem = !rst && mem_valid && (!alu_valid || (prio == PRIO_MEM));
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Clear for the retiring write first, then set for a new reservation, so a
  // same-edge set of the same register wins (a new producer is in flight).
  always_comb begin
    busy_next = busy;
    if (grant_alu) busy_next[alu_rd] = 1'b0;
    if (grant_mem) busy_next[mem_rd] = 1'b0;
    if (reserve_en) busy_next[reserve_address] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio                <= PRIO_ALU;
      busy                <= '0;
      register_write_en   <= 1'b0;
      rd_address          <= '0;
      register_write_data <= '0;
    end else begin
      busy              <= busy_next;
      register_write_en <= 1'b0;
      if (grant_alu) begin
        rd_address          <= alu_rd;
        register_write_data <= alu_data;
        register_write_en   <= (alu_rd != 5'd0);
        prio                <= PRIO_MEM;
      end else if (grant_mem) begin
        rd_address          <= mem_rd;
        register_write_data <= mem_data;
        register_write_en   <= (mem_rd != 5'd0);
        prio                <= PRIO_ALU;
      end
    end
  end

  assign query_a_busy = busy[query_a_address];
  assign query_b_busy = busy[query_b_address];
  assign stall        = query_a_busy | query_b_busy;

endmodule

// File: tb/tb_writeback_arbiter.sv
`timescale 1ns/1ps
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, reserve_en;
  logic [4:0]  alu_rd, mem_rd, reserve_address, query_a_address, query_b_address;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, query_a_busy, query_b_busy, stall;
  logic        register_write_en;
  logic [4:0]  rd_address;
  logic [31:0] register_write_data;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [4:0]  last_rd;
  logic [31:0] last_data;
  int          n_checks = 0;
  int          n_fail   = 0;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .reserve_en(reserve_en), .reserve_address(reserve_address),
    .query_a_address(query_a_address), .query_b_address(query_b_address),
    .query_a_busy(query_a_busy), .query_b_busy(query_b_busy), .stall(stall),
    .register_write_en(register_write_en), .rd_address(rd_address),
    .register_write_data(register_write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs
  // just after, push the expected write, then pop/compare after the rising edge.
  task automatic cycle(input string tag,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic ren, input logic [4:0] raddr,
                       input logic exp_ar, input logic exp_mr,
                       input logic exp_ba, input logic exp_bb);
    wr_t e;
    wr_t got;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    reserve_en = ren; reserve_address = raddr;
    #1;
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(exp_ar));
    check({tag, ".mem_ready"}, 32'(mem_ready), 32'(exp_mr));
    check({tag, ".busy_a"}, 32'(query_a_busy), 32'(exp_ba));
    check({tag, ".busy_b"}, 32'(query_b_busy), 32'(exp_bb));
    check({tag, ".stall"}, 32'(stall), 32'(exp_ba | exp_bb));
    if (exp_ar)      e = '{we: (ard != 5'd0), rd: ard, data: ad};
    else if (exp_mr) e = '{we: (mrd != 5'd0), rd: mrd, data: md};
    else             e = '{we: 1'b0, rd: last_rd, data: last_data};
    last_rd = e.rd; last_data = e.data;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    check({tag, ".write_en"}, 32'(register_write_en), 32'(got.we));
    check({tag, ".rd_address"}, 32'(rd_address), 32'(got.rd));
    check({tag, ".write_data"}, register_write_data, got.data);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic exp_ba, input logic exp_bb);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_ba, exp_bb);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'd0);
    check({tag, ".mem_ready"}, 32'(mem_ready), 32'd0);
    check({tag, ".write_en"}, 32'(register_write_en), 32'd0);
    check({tag, ".rd_address"}, 32'(rd_address), 32'd0);
    check({tag, ".write_data"}, register_write_data, 32'd0);
    check({tag, ".busy_a"}, 32'(query_a_busy), 32'd0);
    check({tag, ".stall"}, 32'(stall), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd6; mem_valid = 1'b1; mem_rd = 5'd8;
    #1;
    reset_checks(tag);
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    last_rd = '0; last_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2;
    reserve_en = 1'b0; reserve_address = '0;
    query_a_address = 5'd0; query_b_address = 5'd0;
    last_rd = '0; last_data = '0;
    #12;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    // single ALU write
    cycle("wr5", 1, 5, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle("wr5_after", 0, 0);

    // alternation from a fresh pointer
    pulse_reset("rst2");
    cycle("rr0", 1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 1, 0, 0, 0);
    cycle("rr1", 1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 1, 0, 0);
    cycle("rr2", 1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 1, 0, 0, 0);
    cycle("rr3", 1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 1, 0, 0);

    // reserve x7, stall until the load writes it back
    query_a_address = 5'd7;
    cycle("res7", 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    idle("hold7", 1, 0);
    cycle("wb7", 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 1, 0);
    idle("free7", 0, 0);

    // same-edge set and clear of x9: set wins
    query_a_address = 5'd0; query_b_address = 5'd9;
    cycle("res9", 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    cycle("setclr9", 1, 9, 32'h99, 0, 0, 0, 1, 9, 1, 0, 0, 1);
    idle("still9", 0, 1);
    // pointer now favours MEM; ALU must hold and win next cycle
    cycle("both9", 1, 9, 32'h999, 1, 10, 32'hAA, 0, 0, 0, 1, 0, 1);
    cycle("alu9", 1, 9, 32'h999, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle("clear9", 0, 0);

    // write to x0 is accepted and discarded; x0 never reads busy
    query_b_address = 5'd0;
    cycle("x0", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    idle("x0_after", 0, 0);

    // write without a prior reservation still happens
    query_b_address = 5'd20;
    cycle("unres20", 0, 0, 0, 1, 20, 32'h2020, 0, 0, 0, 1, 0, 0);
    query_b_address = 5'd0;

    // asynchronous reset after a grant
    query_a_address = 5'd12;
    cycle("pre_rst", 1, 3, 32'h33, 0, 0, 0, 1, 12, 1, 0, 0, 0);
    rst = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    check("async.write_en", 32'(register_write_en), 32'd0);
    check("async.busy12", 32'(query_a_busy), 32'd0);
    check("async.alu_ready", 32'(alu_ready), 32'd0);
    check("async.mem_ready", 32'(mem_ready), 32'd0);
    check("async.rd_address", 32'(rd_address), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0; last_data = '0;
    idle("post_rst", 0, 0);
    cycle("post_rst_ptr", 1, 4, 32'h44, 1, 5, 32'h55, 0, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no end of sequence, expected end before 50000ns");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
